// File: rtl/io_read_port_buffer_pkg.sv
// rtl/io_read_port_buffer_pkg.sv - shared constants, count encoding and clog2 for the read port buffer
package io_read_port_buffer_pkg;

  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } fifo_cnt_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/io_read_port_buffer_if.sv
// rtl/io_read_port_buffer_if.sv - producer and read-port bus bundle for io_read_port_buffer
interface io_read_port_buffer_if #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int PORT_COUNT = 4
);
  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data;
  logic [PORT_COUNT-1:0]            in_valid;
  logic [PORT_COUNT-1:0]            in_ready;
  logic [PORT_COUNT-1:0]            port_EF;
  logic                             rd_en;
  logic [ADDR_WIDTH-1:0]            rd_addr;
  logic [WORD_WIDTH-1:0]            rd_data;
  logic                             rd_data_valid;
  logic                             rd_underflow;

  modport master (
    output in_data, in_valid, rd_en, rd_addr,
    input  in_ready, port_EF, rd_data, rd_data_valid, rd_underflow
  );

  modport slave (
    input  in_data, in_valid, rd_en, rd_addr,
    output in_ready, port_EF, rd_data, rd_data_valid, rd_underflow
  );
endinterface

// File: rtl/io_read_port_buffer_fifo2.sv
// rtl/io_read_port_buffer_fifo2.sv - two-entry per-port FIFO (io_port_fifo2) with registered ready and EF
module io_port_fifo2
  import io_read_port_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 36
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_pop,
  output logic                  o_nonempty,
  output logic [WORD_WIDTH-1:0] o_head,
  output logic                  o_ef
);

  fifo_cnt_e             r_cnt;
  fifo_cnt_e             w_cnt_nxt;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [WORD_WIDTH-1:0] r_mem [2];
  logic                  r_in_ready;
  logic                  r_ef;
  logic                  w_push;
  logic                  w_pop;

  assign w_push     = i_valid & r_in_ready;
  assign w_pop      = i_pop & (r_cnt != CNT_EMPTY);
  assign o_nonempty = (r_cnt != CNT_EMPTY);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_ready    = r_in_ready;
  assign o_ef       = r_ef;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cnt <= CNT_EMPTY;
    else          r_cnt <= w_cnt_nxt;
  end

  // Push with pop on ONE keeps the count; TWO never sees a push since ready is low.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10: begin
        case (r_cnt)
          CNT_EMPTY: w_cnt_nxt = CNT_ONE;
          CNT_ONE:   w_cnt_nxt = CNT_TWO;
          default:   w_cnt_nxt = r_cnt;
        endcase
      end
      2'b01: begin
        case (r_cnt)
          CNT_TWO: w_cnt_nxt = CNT_ONE;
          CNT_ONE: w_cnt_nxt = CNT_EMPTY;
          default: w_cnt_nxt = r_cnt;
        endcase
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_in_ready <= FALSE;
      r_ef       <= EMPTY;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_in_ready <= (w_cnt_nxt == CNT_TWO) ? FALSE : TRUE;
      r_ef       <= (w_cnt_nxt != CNT_EMPTY) ? FULL : EMPTY;
    end
  end

endmodule

// File: rtl/io_read_port_buffer.sv
// rtl/io_read_port_buffer.sv - per-port input FIFOs with address-decoded read pop and underflow flag
module io_read_port_buffer
  import io_read_port_buffer_pkg::*;
#(
  parameter int WORD_WIDTH      = 36,
  parameter int ADDR_WIDTH      = 10,
  parameter int PORT_COUNT      = 4,
  parameter int PORT_BASE_ADDR  = 0,
  parameter int PORT_ADDR_WIDTH = (clog2(PORT_COUNT) < 1) ? 1 : clog2(PORT_COUNT)
) (
  input logic                  clock,
  input logic                  reset_n,
  io_read_port_buffer_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]      BASE_EXT  = (ADDR_WIDTH+1)'(PORT_BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]      LIMIT_EXT = (ADDR_WIDTH+1)'(PORT_BASE_ADDR + PORT_COUNT);
  localparam logic [PORT_ADDR_WIDTH-1:0] BASE_LO = PORT_ADDR_WIDTH'(PORT_BASE_ADDR);

  logic [WORD_WIDTH-1:0]      w_head [PORT_COUNT];
  logic [PORT_COUNT-1:0]      w_nonempty;
  logic [PORT_COUNT-1:0]      w_pop;
  logic [PORT_COUNT-1:0]      w_ready;
  logic [PORT_COUNT-1:0]      w_ef;
  logic [ADDR_WIDTH:0]        w_addr_ext;
  logic                       w_hit;
  logic                       w_rd_hit;
  logic [PORT_ADDR_WIDTH-1:0] w_idx;
  logic                       w_sel_nonempty;
  logic [WORD_WIDTH-1:0]      w_sel_head;
  logic                       w_pop_any;
  logic                       w_underflow;
  logic [WORD_WIDTH-1:0]      r_rd_data;
  logic                       r_rd_data_valid;
  logic                       r_rd_underflow;

  // Range check uses an extra bit so BASE+PORT_COUNT cannot wrap past the top of the address space.
  assign w_addr_ext = {1'b0, bus.rd_addr};
  assign w_hit      = (w_addr_ext >= BASE_EXT) && (w_addr_ext < LIMIT_EXT);
  assign w_rd_hit   = bus.rd_en & w_hit;
  assign w_idx      = bus.rd_addr[PORT_ADDR_WIDTH-1:0] - BASE_LO;

  always_comb begin
    w_sel_nonempty = 1'b0;
    w_sel_head     = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (w_idx == PORT_ADDR_WIDTH'(i)) begin
        w_sel_nonempty = w_nonempty[i];
        w_sel_head     = w_head[i];
      end
    end
  end

  assign w_pop_any   = w_rd_hit & w_sel_nonempty;
  assign w_underflow = w_rd_hit & ~w_sel_nonempty;

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    assign w_pop[g] = w_rd_hit & (w_idx == PORT_ADDR_WIDTH'(g)) & w_nonempty[g];

    io_port_fifo2 #(.WORD_WIDTH(WORD_WIDTH)) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_data     (bus.in_data[g*WORD_WIDTH +: WORD_WIDTH]),
      .i_valid    (bus.in_valid[g]),
      .o_ready    (w_ready[g]),
      .i_pop      (w_pop[g]),
      .o_nonempty (w_nonempty[g]),
      .o_head     (w_head[g]),
      .o_ef       (w_ef[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
      r_rd_underflow  <= 1'b0;
    end else begin
      if (w_pop_any) r_rd_data <= w_sel_head;
      r_rd_data_valid <= w_pop_any;
      r_rd_underflow  <= w_underflow;
    end
  end

  assign bus.in_ready      = w_ready;
  assign bus.port_EF       = w_ef;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_data_valid = r_rd_data_valid;
  assign bus.rd_underflow  = r_rd_underflow;

endmodule

// File: tb/tb_io_read_port_buffer.sv
// tb/tb_io_read_port_buffer.sv - randomized and directed bench for io_read_port_buffer against a queue model
module tb_io_read_port_buffer;

  localparam int WW   = 36;
  localparam int AW   = 10;
  localparam int PC   = 4;
  localparam int BASE = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  io_read_port_buffer_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PORT_COUNT(PC)) bus ();

  io_read_port_buffer #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PORT_COUNT(PC), .PORT_BASE_ADDR(BASE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [WW-1:0] q [PC][$];
  logic [PC-1:0] m_ready;
  logic [WW-1:0] m_data;
  logic          m_valid;
  logic          m_uf;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [PC-1:0] exp_ef;
    for (int i = 0; i < PC; i++) exp_ef[i] = (q[i].size() > 0);
    check("in_ready", 64'(bus.in_ready), 64'(m_ready));
    check("port_EF", 64'(bus.port_EF), 64'(exp_ef));
    check("rd_data_valid", 64'(bus.rd_data_valid), 64'(m_valid));
    check("rd_underflow", 64'(bus.rd_underflow), 64'(m_uf));
    check("rd_data", 64'(bus.rd_data), 64'(m_data));
  endtask

  // Inputs are applied after a falling edge; the model consumes them at the rising edge.
  task automatic step();
    bit hit;
    int idx;
    @(posedge clock);
    hit = bus.rd_en && (int'(bus.rd_addr) >= BASE) && (int'(bus.rd_addr) < BASE + PC);
    idx = int'(bus.rd_addr) - BASE;
    m_valid = 1'b0;
    m_uf    = 1'b0;
    if (hit) begin
      if (q[idx].size() > 0) begin
        m_data  = q[idx].pop_front();
        m_valid = 1'b1;
      end else begin
        m_uf = 1'b1;
      end
    end
    for (int i = 0; i < PC; i++)
      if (bus.in_valid[i] && m_ready[i]) q[i].push_back(bus.in_data[i*WW +: WW]);
    for (int i = 0; i < PC; i++) m_ready[i] = (q[i].size() < 2);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.in_valid = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
  endtask

  task automatic push1(input int port, input logic [WW-1:0] val);
    idle();
    bus.in_valid[port]          = 1'b1;
    bus.in_data[port*WW +: WW]  = val;
    step();
    idle();
  endtask

  task automatic read1(input int addr);
    idle();
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    step();
    idle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < PC; i++) q[i].delete();
    m_ready = '0;
    m_data  = '0;
    m_valid = 1'b0;
    m_uf    = 1'b0;
  endtask

  initial begin
    logic [WW-1:0] rnd;
    bus.in_data = '0;
    idle();
    model_reset();

    repeat (3) @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    step();
    check("ready_after_release", 64'(bus.in_ready), 64'hF);

    // fill and drain port 2
    push1(2, 36'h123);
    push1(2, 36'h456);
    check("p2_full_not_ready", 64'(bus.in_ready[2]), 64'h0);
    read1(BASE + 2);
    check("p2_first", 64'(bus.rd_data), 64'h123);
    read1(BASE + 2);
    check("p2_second", 64'(bus.rd_data), 64'h456);
    check("p2_drained", 64'(bus.port_EF[2]), 64'h0);

    // steady stream on port 0
    push1(0, 36'd1);
    for (int k = 1; k <= 100; k++) begin
      bus.in_valid[0]      = (k < 100);
      bus.in_data[0 +: WW] = WW'(k + 1);
      bus.rd_en            = 1'b1;
      bus.rd_addr          = AW'(BASE);
      step();
      check("stream_data", 64'(bus.rd_data), 64'(k));
    end
    idle();
    step();

    // empty read, out-of-range and masked reads
    read1(BASE + 1);
    check("empty_uf", 64'(bus.rd_underflow), 64'h1);
    step();
    check("uf_one_cycle", 64'(bus.rd_underflow), 64'h0);
    push1(0, 36'hABC);
    read1(BASE + PC);
    idle();
    bus.rd_addr = AW'(BASE);
    step();
    check("masked_no_pop", 64'(bus.port_EF[0]), 64'h1);
    read1(BASE);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < PC; i++) begin
        rnd = {$urandom, $urandom};
        bus.in_valid[i]          = ($urandom_range(0, 1) == 1);
        bus.in_data[i*WW +: WW]  = rnd;
      end
      bus.rd_en   = ($urandom_range(0, 9) < 6);
      bus.rd_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, PC + 1));
      step();
    end
    idle();
    for (int i = 0; i < PC; i++) while (q[i].size() > 0) read1(BASE + i);

    // reset mid-operation with ports at TWO/ONE/EMPTY/ONE
    bus.in_valid = 4'b1011;
    step();
    bus.in_valid = 4'b0001;
    step();
    idle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_ef_clear", 64'(bus.port_EF), 64'h0);
    check("async_ready_clear", 64'(bus.in_ready), 64'h0);
    #1 reset_n = 1'b1;
    step();
    for (int i = 0; i < PC; i++) begin
      read1(BASE + i);
      check("post_reset_uf", 64'(bus.rd_underflow), 64'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
